control_hazard_unit: RTL and testbench

Sequential successor to the purely combinational control-hazard check in the 5-stage pipeline. It classifies the instruction in decode, tracks in-flight control transfers with a down-counter FSM, and drives fetch stall, decode bubble and per-stage flush outputs. It has two modes: stall-until-resolve (MODE=0) and predict-not-taken with squash on taken (MODE=1). It sits beside the hazard/forwarding logic and feeds the IF/ID and ID/EX pipeline-register control inputs plus the PC-select mux.

---
 rtl/control_hazard_unit_pkg.sv | 28 ++
 rtl/ctrl_op_classifier.sv | 24 ++
 rtl/control_hazard_unit.sv | 143 ++++++++++++++
 tb/tb_control_hazard_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/control_hazard_unit_pkg.sv
// Shared definitions for the control-hazard unit and its opcode classifier.
//   - 5-bit opcode constants for conditional branches and jumps
//   - FSM state encoding
//   - operating mode selectors
package control_hazard_unit_pkg;

  // Jumps: 00100..00111
  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_JR   = 5'b00101;
  localparam logic [4:0] OP_JAL  = 5'b00110;
  localparam logic [4:0] OP_JALR = 5'b00111;

  // Conditional branches: 01100..01111
  localparam logic [4:0] OP_BEQZ = 5'b01100;
  localparam logic [4:0] OP_BNEZ = 5'b01101;
  localparam logic [4:0] OP_BLTZ = 5'b01110;
  localparam logic [4:0] OP_BGEZ = 5'b01111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int MODE_STALL = 0;  // stall fetch until the outcome is final
  localparam int MODE_PNT   = 1;  // predict not-taken, squash on taken

endpackage

// File: rtl/ctrl_op_classifier.sv
// Combinational opcode classifier shared with the forwarding unit.
// Ports:
//   opcode : 5-bit major opcode of the instruction
//   cond   : opcode is a conditional branch (BEQZ/BNEZ/BLTZ/BGEZ)
//   jump   : opcode is an unconditional jump (J/JR/JAL/JALR)
module ctrl_op_classifier
  import control_hazard_unit_pkg::*;
(
  input  logic [4:0] opcode,
  output logic       cond,
  output logic       jump
);

  always_comb begin
    cond = 1'b0;
    jump = 1'b0;
    case (opcode)
      OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: cond = 1'b1;
      OP_J, OP_JR, OP_JAL, OP_JALR:       jump = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_hazard_unit.sv
// Sequential control-hazard unit for the 5-stage pipeline. Classifies the
// instruction in decode, tracks in-flight control transfers and drives the
// fetch stall, decode bubble, per-stage flush and PC redirect controls.
//
//   state | meaning
//   IDLE  | no control transfer outstanding
//   WAIT  | stall mode: holding fetch until the branch resolves (cnt counts down)
//   FLUSH | predict-not-taken mode: one-cycle recovery after a taken squash
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   instr_decode      : instruction in decode; opcode is the top 5 bits
//   id_valid          : decode holds a real instruction
//   pipe_stall        : downstream stall, freezes all state here
//   branch_resolved   : a control outcome is final this cycle
//   branch_taken      : outcome qualifier for branch_resolved
//   stall_fetch       : hold PC and IF/ID
//   bubble_decode     : insert NOP into ID/EX
//   flush_mask        : bit i squashes pipeline register i
//   redirect          : PC mux selects the resolved target
//   busy              : FSM not idle
//   ctrl_count        : accepted control instructions (saturating)
//   flush_count       : taken-branch flush events (saturating)
module control_hazard_unit
  import control_hazard_unit_pkg::*;
#(
  parameter int INSTR_W       = 16,
  parameter int RESOLVE_DEPTH = 3,
  parameter int MODE          = 0,
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INSTR_W-1:0]       instr_decode,
  input  logic                     id_valid,
  input  logic                     pipe_stall,
  input  logic                     branch_resolved,
  input  logic                     branch_taken,
  output logic                     stall_fetch,
  output logic                     bubble_decode,
  output logic [RESOLVE_DEPTH-1:0] flush_mask,
  output logic                     redirect,
  output logic                     busy,
  output logic [CNT_W-1:0]         ctrl_count,
  output logic [CNT_W-1:0]         flush_count
);

  localparam int              CW       = $clog2(RESOLVE_DEPTH + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(RESOLVE_DEPTH);
  localparam logic [CNT_W-1:0] STAT_MAX = '1;
  localparam bit              PNT      = (MODE == MODE_PNT);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [CNT_W-1:0] ctrl_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic is_cond, is_jump;
  logic is_ctrl, is_idle, take, accept;
  logic unused_instr_low;

  ctrl_op_classifier u_classifier (
    .opcode (instr_decode[INSTR_W-1 -: 5]),
    .cond   (is_cond),
    .jump   (is_jump)
  );

  // Only the opcode field matters for classification.
  assign unused_instr_low = ^instr_decode[INSTR_W-6:0];

  assign is_ctrl = (is_cond | is_jump) & id_valid;
  assign is_idle = (state == ST_IDLE);

  // A taken resolve wins over a control instruction sitting in decode: that
  // instruction is on the wrong path and gets squashed, so it is not accepted.
  assign take   = PNT & branch_resolved & branch_taken & ~pipe_stall & is_idle;
  assign accept = is_ctrl & ~pipe_stall & is_idle & ~take;

  // Outputs are decoded from the current state and inputs; an asserted reset
  // forces them low in the same cycle.
  always_comb begin
    stall_fetch   = 1'b0;
    bubble_decode = 1'b0;
    flush_mask    = '0;
    redirect      = 1'b0;
    if (!rst) begin
      if (PNT) begin
        if (take) begin
          flush_mask = '1;
          redirect   = 1'b1;
        end
      end else begin
        redirect = branch_resolved & branch_taken;
        if (state == ST_WAIT || accept) begin
          stall_fetch   = 1'b1;
          bubble_decode = 1'b1;
        end
      end
    end
  end

  assign busy        = ~rst & ~is_idle;
  assign ctrl_count  = ctrl_cnt_q;
  assign flush_count = flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      ctrl_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (accept && ctrl_cnt_q != STAT_MAX)
        ctrl_cnt_q <= ctrl_cnt_q + CNT_W'(1);
      if (take && flush_cnt_q != STAT_MAX)
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);

      case (state)
        ST_IDLE: begin
          if (!PNT && accept) begin
            state <= ST_WAIT;
            cnt   <= CNT_LOAD;
          end else if (take) begin
            state <= ST_FLUSH;
          end
        end
        ST_WAIT: begin
          if (!pipe_stall) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1))
              state <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (!pipe_stall)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_hazard_unit.sv
// Bench for control_hazard_unit: three instances share one input stream
//   u0: stall mode, depth 3, 16-bit counters
//   u1: predict-not-taken, depth 3, 16-bit counters
//   u2: stall mode, depth 1, 4-bit counters
// A behavioural model predicts every output each cycle; directed literal
// expectations pin the model on the key scenarios.
module tb_control_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, id_valid, pipe_stall, br_res, br_tk;
  logic [15:0] instr;

  logic        sf0, bd0, rd0, bz0;  logic [2:0] fm0; logic [15:0] cc0, fc0;
  logic        sf1, bd1, rd1, bz1;  logic [2:0] fm1; logic [15:0] cc1, fc1;
  logic        sf2, bd2, rd2, bz2;  logic [0:0] fm2; logic [3:0]  cc2, fc2;

  logic        sf[3], bd[3], rd[3], bz[3];
  logic [3:0]  fm[3];
  logic [15:0] cc[3], fc[3];

  assign sf[0] = sf0; assign bd[0] = bd0; assign rd[0] = rd0; assign bz[0] = bz0;
  assign sf[1] = sf1; assign bd[1] = bd1; assign rd[1] = rd1; assign bz[1] = bz1;
  assign sf[2] = sf2; assign bd[2] = bd2; assign rd[2] = rd2; assign bz[2] = bz2;
  assign fm[0] = {1'b0, fm0}; assign fm[1] = {1'b0, fm1}; assign fm[2] = {3'b0, fm2};
  assign cc[0] = cc0; assign cc[1] = cc1; assign cc[2] = {12'b0, cc2};
  assign fc[0] = fc0; assign fc[1] = fc1; assign fc[2] = {12'b0, fc2};

  control_hazard_unit #(.INSTR_W(16), .RESOLVE_DEPTH(3), .MODE(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .instr_decode(instr), .id_valid(id_valid),
    .pipe_stall(pipe_stall), .branch_resolved(br_res), .branch_taken(br_tk),
    .stall_fetch(sf0), .bubble_decode(bd0), .flush_mask(fm0), .redirect(rd0),
    .busy(bz0), .ctrl_count(cc0), .flush_count(fc0));

  control_hazard_unit #(.INSTR_W(16), .RESOLVE_DEPTH(3), .MODE(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .instr_decode(instr), .id_valid(id_valid),
    .pipe_stall(pipe_stall), .branch_resolved(br_res), .branch_taken(br_tk),
    .stall_fetch(sf1), .bubble_decode(bd1), .flush_mask(fm1), .redirect(rd1),
    .busy(bz1), .ctrl_count(cc1), .flush_count(fc1));

  control_hazard_unit #(.INSTR_W(16), .RESOLVE_DEPTH(1), .MODE(0), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .instr_decode(instr), .id_valid(id_valid),
    .pipe_stall(pipe_stall), .branch_resolved(br_res), .branch_taken(br_tk),
    .stall_fetch(sf2), .bubble_decode(bd2), .flush_mask(fm2), .redirect(rd2),
    .busy(bz2), .ctrl_count(cc2), .flush_count(fc2));

  // Instance configuration as seen by the model
  int md[3]  = '{0, 1, 0};
  int dep[3] = '{3, 3, 1};
  int cw[3]  = '{16, 16, 4};

  // Model state: stall cycles still owed, flush recovery pending, event totals
  int     wait_left[3];
  bit     in_flush[3];
  longint nctrl[3], nflush[3];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic bit is_ctrl_instr(input logic [15:0] ins, input logic v);
    int op;
    op = int'(ins[15:11]);
    return v && ((op >= 4 && op <= 7) || (op >= 12 && op <= 15));
  endfunction

  function automatic longint sat(input longint n, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  // Compare all instances against the model, then advance the model across
  // the coming clock edge.
  task automatic check_model();
    for (int k = 0; k < 3; k++) begin
      bit idle, take, acc, e_sf, e_rd, e_bz;
      int e_fm;
      idle = md[k] ? !in_flush[k] : (wait_left[k] == 0);
      take = md[k] && br_res && br_tk && !pipe_stall && idle;
      acc  = is_ctrl_instr(instr, id_valid) && !pipe_stall && idle && !take;
      if (rst) begin
        e_sf = 0; e_rd = 0; e_bz = 0; e_fm = 0;
      end else if (md[k] == 0) begin
        e_sf = !idle || acc;
        e_rd = br_res && br_tk;
        e_bz = !idle;
        e_fm = 0;
      end else begin
        e_sf = 0;
        e_rd = take;
        e_bz = !idle;
        e_fm = take ? ((1 << dep[k]) - 1) : 0;
      end
      chk($sformatf("u%0d.stall_fetch", k),   longint'(sf[k]), longint'(e_sf));
      chk($sformatf("u%0d.bubble_decode", k), longint'(bd[k]), longint'(e_sf));
      chk($sformatf("u%0d.redirect", k),      longint'(rd[k]), longint'(e_rd));
      chk($sformatf("u%0d.busy", k),          longint'(bz[k]), longint'(e_bz));
      chk($sformatf("u%0d.flush_mask", k),    longint'(fm[k]), longint'(e_fm));
      if (!rst) begin
        chk($sformatf("u%0d.ctrl_count", k),  longint'(cc[k]), sat(nctrl[k], cw[k]));
        chk($sformatf("u%0d.flush_count", k), longint'(fc[k]), sat(nflush[k], cw[k]));
      end

      if (rst) begin
        wait_left[k] = 0; in_flush[k] = 0; nctrl[k] = 0; nflush[k] = 0;
      end else if (!pipe_stall) begin
        if (acc) nctrl[k]++;
        if (take) nflush[k]++;
        if (md[k] == 0) begin
          if (idle) begin
            if (acc) wait_left[k] = dep[k];
          end else begin
            wait_left[k]--;
          end
        end else begin
          in_flush[k] = take;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [15:0] ins, input logic v,
                      input logic ps, input logic res, input logic tk);
    @(posedge clk);
    #1;
    rst = r; instr = ins; id_valid = v; pipe_stall = ps; br_res = res; br_tk = tk;
    @(negedge clk);
    check_model();
  endtask

  task automatic idle_step();
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; instr = '0; id_valid = 0; pipe_stall = 0; br_res = 0; br_tk = 0;
    for (int k = 0; k < 3; k++) begin
      wait_left[k] = 0; in_flush[k] = 0; nctrl[k] = 0; nflush[k] = 0;
    end

    step(1, 16'h0000, 0, 0, 0, 0);
    step(1, 16'h0000, 0, 0, 0, 0);
    idle_step();
    chk("reset.stall_fetch", longint'(sf0), 0);
    chk("reset.busy",        longint'(bz0), 0);
    chk("reset.ctrl_count",  longint'(cc0), 0);
    chk("reset.flush_count", longint'(fc1), 0);

    // BEQZ in stall mode: fetch held for four cycles, busy for three
    step(0, 16'h6000, 1, 0, 0, 0);
    chk("t1.stall_t0", longint'(sf0), 1);
    chk("t1.busy_t0",  longint'(bz0), 0);
    idle_step();
    chk("t1.stall_t1", longint'(sf0), 1);
    chk("t1.busy_t1",  longint'(bz0), 1);
    idle_step();
    idle_step();
    chk("t1.stall_t3", longint'(sf0), 1);
    idle_step();
    chk("t1.stall_t4", longint'(sf0), 0);
    chk("t1.busy_t4",  longint'(bz0), 0);
    chk("t1.ctrl_count", longint'(cc0), 1);

    // Two stalled cycles stretch the window to six
    step(0, 16'h6000, 1, 0, 0, 0);
    idle_step();
    step(0, 16'h0000, 0, 1, 0, 0);
    step(0, 16'h0000, 0, 1, 0, 0);
    idle_step();
    idle_step();
    chk("t2.stall_t5", longint'(sf0), 1);
    idle_step();
    chk("t2.stall_t6", longint'(sf0), 0);
    chk("t2.ctrl_count", longint'(cc0), 2);

    // Reset in the middle of WAIT
    step(0, 16'h6000, 1, 0, 0, 0);
    idle_step();
    step(1, 16'h0000, 0, 0, 0, 0);
    idle_step();
    chk("t2.rst_stall", longint'(sf0), 0);
    chk("t2.rst_bubble", longint'(bd0), 0);
    chk("t2.rst_busy",  longint'(bz0), 0);
    chk("t2.rst_count", longint'(cc0), 0);

    // Invalid J and a valid non-control opcode do nothing
    step(0, 16'h2000, 0, 0, 0, 0);
    chk("t3.j_invalid_stall", longint'(sf0), 0);
    step(0, 16'h0800, 1, 0, 0, 0);
    chk("t3.noctrl_stall", longint'(sf0), 0);
    idle_step();
    chk("t3.ctrl_count", longint'(cc0), 0);

    // Predict-not-taken: BNEZ, taken two cycles later
    step(0, 16'h6800, 1, 0, 0, 0);
    idle_step();
    step(0, 16'h0000, 0, 0, 1, 1);
    chk("t4.flush_mask", longint'(fm1), 7);
    chk("t4.redirect",   longint'(rd1), 1);
    chk("t4.no_stall",   longint'(sf1), 0);
    idle_step();
    chk("t4.flush_mask_after", longint'(fm1), 0);
    chk("t4.redirect_after",   longint'(rd1), 0);
    chk("t4.busy_flush",       longint'(bz1), 1);
    chk("t4.flush_count",      longint'(fc1), 1);
    chk("t4.ctrl_count",       longint'(cc1), 1);

    // Taken resolve squashes the JAL in decode; not-taken is silent
    idle_step();
    step(0, 16'h3000, 1, 0, 1, 1);
    chk("t5.flush_mask", longint'(fm1), 7);
    idle_step();
    chk("t5.ctrl_count", longint'(cc1), 1);
    chk("t5.flush_count", longint'(fc1), 2);
    idle_step();
    step(0, 16'h0000, 0, 0, 1, 0);
    chk("t5.nt_flush_mask", longint'(fm1), 0);
    chk("t5.nt_redirect",   longint'(rd1), 0);

    // Saturation of the 4-bit counter (depth 1 accepts every other cycle)
    repeat (60) step(0, 16'h6000, 1, 0, 0, 0);
    chk("t6.ctrl_count_sat", longint'(cc2), 15);
    idle_step();
    idle_step();
    chk("t6.ctrl_count_hold", longint'(cc2), 15);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic        r, v, ps, res, tk;
      logic [15:0] ins;
      r   = ($urandom_range(0, 99) < 2);
      ins = 16'($urandom);
      v   = ($urandom_range(0, 3) != 0);
      ps  = ($urandom_range(0, 99) < 20);
      res = ($urandom_range(0, 99) < 30);
      tk  = 1'($urandom);
      step(r, ins, v, ps, res, tk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
